// File: rtl/pixel_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | pixel_mem_arbiter                                                        |
// | Round-robin burst arbiter for port A of the pixel memory (R1 loader,     |
// | R2 processor) with tagged read-data return through the memory latency.   |
// | Option: `define PIXEL_ARB_FIXED_PRIO_EN for fixed R1 priority.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pixel_mem_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 8,
    parameter int READ_LAT  = 1,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              req_1,
    input  logic              we_1,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [DATA_W-1:0] wdata_1,
    output logic              gnt_1,
    output logic              rvalid_1,
    input  logic              req_2,
    input  logic              we_2,
    input  logic [ADDR_W-1:0] addr_2,
    input  logic [DATA_W-1:0] wdata_2,
    output logic              gnt_2,
    output logic              rvalid_2,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_select,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_GNT1 = 2'd1;
    localparam logic [1:0] c_GNT2 = 2'd2;

    localparam int                 c_CNT_W    = $clog2(MAX_BURST);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MAX_BURST - 1);

    logic [1:0]         r_state, w_next_state;
    logic               r_last_r2, w_next_last_r2;
    logic [c_CNT_W-1:0] r_burst_cnt, w_next_burst_cnt;
    logic               r_gnt_1, r_gnt_2;
    logic               w_beat_1, w_beat_2, w_burst_done;
    logic               w_r1_wins_tie, w_limit_1;
    logic               w_rd_push, w_rd_tag;
    logic [READ_LAT-1:0] r_tag_v, r_tag_r2;

`ifdef PIXEL_ARB_FIXED_PRIO_EN
    assign w_r1_wins_tie = 1'b1;
    assign w_limit_1     = 1'b0;
`else
    assign w_r1_wins_tie = r_last_r2;
    assign w_limit_1     = 1'b1;
`endif

    assign w_beat_1     = (r_state == c_GNT1) & req_1;
    assign w_beat_2     = (r_state == c_GNT2) & req_2;
    assign w_burst_done = (w_beat_1 | w_beat_2) & (r_burst_cnt == c_CNT_LAST);

    // State register; grant flags are registered from the next state.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= c_IDLE;
            r_last_r2   <= 1'b1;
            r_burst_cnt <= '0;
            r_gnt_1     <= 1'b0;
            r_gnt_2     <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_last_r2   <= w_next_last_r2;
            r_burst_cnt <= w_next_burst_cnt;
            r_gnt_1     <= (w_next_state == c_GNT1);
            r_gnt_2     <= (w_next_state == c_GNT2);
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_next_last_r2   = r_last_r2;
        w_next_burst_cnt = r_burst_cnt;
        case (r_state)
            c_IDLE: begin
                w_next_burst_cnt = '0;
                if (req_1 && (!req_2 || w_r1_wins_tie))
                    w_next_state = c_GNT1;
                else if (req_2)
                    w_next_state = c_GNT2;
            end
            c_GNT1: begin
                if (!req_1) begin
                    w_next_state     = req_2 ? c_GNT2 : c_IDLE;
                    w_next_last_r2   = 1'b0;
                    w_next_burst_cnt = '0;
                end else if (w_burst_done) begin
                    w_next_burst_cnt = '0;
                    if (w_limit_1 && req_2) begin
                        w_next_state   = c_GNT2;
                        w_next_last_r2 = 1'b0;
                    end
                end else begin
                    w_next_burst_cnt = r_burst_cnt + c_CNT_W'(1);
                end
            end
            c_GNT2: begin
                if (!req_2) begin
                    w_next_state     = req_1 ? c_GNT1 : c_IDLE;
                    w_next_last_r2   = 1'b1;
                    w_next_burst_cnt = '0;
                end else if (w_burst_done) begin
                    w_next_burst_cnt = '0;
                    if (req_1) begin
                        w_next_state   = c_GNT1;
                        w_next_last_r2 = 1'b1;
                    end
                end else begin
                    w_next_burst_cnt = r_burst_cnt + c_CNT_W'(1);
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // Port A follows the granted requester; R1 drives it while idle.
    always_comb begin
        mem_addr  = addr_1;
        mem_wdata = wdata_1;
        mem_wren  = w_beat_1 & we_1;
        if (r_state == c_GNT2) begin
            mem_addr  = addr_2;
            mem_wdata = wdata_2;
            mem_wren  = w_beat_2 & we_2;
        end
    end

    assign gnt_1      = r_gnt_1;
    assign gnt_2      = r_gnt_2;
    assign mem_select = r_gnt_2;

    assign w_rd_push = (w_beat_1 & ~we_1) | (w_beat_2 & ~we_2);
    assign w_rd_tag  = w_beat_2;

    generate
        if (READ_LAT == 1) begin : g_tag_lat1
            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    r_tag_v  <= '0;
                    r_tag_r2 <= '0;
                end else begin
                    r_tag_v  <= w_rd_push;
                    r_tag_r2 <= w_rd_tag;
                end
            end
        end else begin : g_tag_latn
            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    r_tag_v  <= '0;
                    r_tag_r2 <= '0;
                end else begin
                    r_tag_v  <= {r_tag_v[READ_LAT-2:0], w_rd_push};
                    r_tag_r2 <= {r_tag_r2[READ_LAT-2:0], w_rd_tag};
                end
            end
        end
    endgenerate

    // mem_q is already the memory's registered output; the tag only qualifies it.
    assign rvalid_1 = r_tag_v[READ_LAT-1] & ~r_tag_r2[READ_LAT-1];
    assign rvalid_2 = r_tag_v[READ_LAT-1] &  r_tag_r2[READ_LAT-1];
    assign rdata    = r_tag_v[READ_LAT-1] ? mem_q : '0;

endmodule
`default_nettype wire
